pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready flow control, flush and bubble insertion.
//  Replaces the fixed free-running ID/EX latch in the 16-bit core.
//  Carries inst, two operands, register-window and packed control fields.
//  An optional 2-entry skid buffer removes the combinational ready path, and the block holds its contents under back-pressure.
//  Invalid slots always present the NOP instruction with all control bits zero (safe bubble).
// PARAMETERS
//  INST_W    16       instruction width
//  DATA_W    16       operand width (rega/regb)
//  WIN_W     2        register-window field width
//  CTRL_W    10       packed control: {AluSrcA,AluSrcB,MemRead,MemWrite,RegWrite,op[2:0],RegData[1:0]}
//  NOP_INST  16'h8040 instruction value presented for a bubble
//  SKID      1        1: 2-entry skid, registered in_ready; 0: single entry, combinational in_ready
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst_n      in   1       synchronous active-low reset
//  flush      in   1       discard all held entries (branch/exception)
//  in_valid   in   1       upstream entry present
//  in_ready   out  1       block accepts entry this cycle
//  in_inst    in   INST_W  instruction
//  in_rega    in   DATA_W  operand A
//  in_regb    in   DATA_W  operand B
//  in_win     in   WIN_W   register window
//  in_ctrl    in   CTRL_W  control bundle
//  out_valid  out  1       entry presented downstream
//  out_ready  in   1       downstream consumes entry
//  out_inst/out_rega/out_regb/out_win/out_ctrl  out  as inputs  presented entry
//  occupancy  out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state EMPTY, out_valid=0, out_inst=NOP_INST, out_rega/regb/win/ctrl=0, occupancy=0, in_ready=1.
//  - Accept = in_valid & in_ready; consume = out_valid & out_ready. Latency in->out is 1 cycle; throughput is 1/cycle.
//  - Outputs come straight from flops (main slot). When out_valid=0 the outputs are NOP_INST with ctrl/data/win = 0.
//  - Input payload may change freely while in_valid=0. Once accepted, the payload is frozen in the slot until consumed.
//  - FSM (SKID=1), states EMPTY/FULL/SKID, in_ready = (state!=SKID), registered:
//      EMPTY: accept -> FULL (main<=in).
//      FULL : accept&consume -> FULL (main<=in); accept&!consume -> SKID (skid<=in);
//             !accept&consume -> EMPTY (main<=bubble); else hold.
//      SKID : consume -> FULL (main<=skid, skid<=bubble); else hold. No accept.
//  - SKID=0: states EMPTY/FULL only; in_ready = !out_valid | out_ready (combinational).
//  - Order is strict FIFO: the skid entry is never overtaken.
//  - flush (rst_n=1): the next state is EMPTY and both slots load the bubble. Any in_valid in the same cycle is dropped and
//    in_ready is still driven (upstream treats the dropped entry as flushed). Consume in the flush cycle is not suppressed.
//  - Priority: rst_n=0 > flush > normal FSM.
//  - occupancy = 0/1/2 for EMPTY/FULL/SKID, registered with the state.
//  - Reset or flush mid-transfer never leaves a non-bubble value on the outputs with out_valid=0.
// STRUCTURE
//  - Shared package pipe_pkg: NOP_INST constant, CTRL_W, ctrl field bit offsets (CTRL_REGWRITE, CTRL_MEMWRITE, ...), state encoding.
//  - Sub-module pipe_slot: one payload register {inst,rega,regb,win,ctrl} with load, clear-to-bubble and synchronous reset.
//    It is instantiated twice (main and skid), with the skid generated only when SKID=1.
//  - Top level contains the FSM, the ready/occupancy logic and the slot muxing.
// TESTING
//  1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_inst=16'h8040, ctrl=0, in_ready=1, occupancy=0.
//  2. Streaming: out_ready=1, inject inst 0x1111,0x2222,0x3333 on consecutive cycles -> these appear one cycle later
//     on consecutive cycles; occupancy stays 1.
//  3. Back-pressure: with out_ready=0, send A then B -> occupancy=2 and in_ready=0; C is held upstream.
//     Raise out_ready -> A, B, C are delivered in order with no loss or duplication.
//  4. Flush in SKID state while in_valid=1 (D) -> next cycle occupancy=0, out_valid=0, out bubble; D never appears.
//  5. Flush and rst_n=0 in the same cycle -> reset values; flush while EMPTY -> no change.
//  6. SKID=0 build: out_ready=0 with FULL -> in_ready=0 in the same cycle; raising out_ready -> in_ready=1 combinationally.
//     Random valid/ready for 10k cycles -> scoreboard shows in-order delivery and zero ctrl while out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline register:
//   - bubble instruction value and default payload field widths
//   - bit offsets of the packed control bundle
//     {AluSrcA, AluSrcB, MemRead, MemWrite, RegWrite, op[2:0], RegData[1:0]}
//   - stage state encoding and its occupancy decode
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int INST_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int WIN_W_DEF  = 2;
  localparam int CTRL_W     = 10;

  localparam logic [15:0] NOP_INST = 16'h8040;

  // Control bundle bit positions (LSB of multi-bit fields)
  localparam int CTRL_REGDATA_LSB = 0;
  localparam int CTRL_OP_LSB      = 2;
  localparam int CTRL_REGWRITE    = 5;
  localparam int CTRL_MEMWRITE    = 6;
  localparam int CTRL_MEMREAD     = 7;
  localparam int CTRL_ALUSRCB     = 8;
  localparam int CTRL_ALUSRCA     = 9;

  // The encoding doubles as the entry count held by the stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  function automatic logic [1:0] state_occupancy(input state_e s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_FULL:  occ = 2'd1;
      ST_SKID:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One payload register {inst, rega, regb, win, ctrl}.
// Priority: rst_n low > clear (load bubble) > load (capture d_*) > hold.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load, clear         capture d_* / load the bubble
//   d_inst..d_ctrl      payload to capture
//   q_inst..q_ctrl      registered payload
// ---------------------------------------------------------------------------
module pipe_slot #(
  parameter int                INST_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                WIN_W    = 2,
  parameter int                CTRL_W   = 10,
  parameter logic [INST_W-1:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] d_inst,
  input  logic [DATA_W-1:0] d_rega,
  input  logic [DATA_W-1:0] d_regb,
  input  logic [WIN_W-1:0]  d_win,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [INST_W-1:0] q_inst,
  output logic [DATA_W-1:0] q_rega,
  output logic [DATA_W-1:0] q_regb,
  output logic [WIN_W-1:0]  q_win,
  output logic [CTRL_W-1:0] q_ctrl
);

  // Payload register: reset and clear both yield the safe bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      q_inst <= NOP_INST;
      q_rega <= {DATA_W{1'b0}};
      q_regb <= {DATA_W{1'b0}};
      q_win  <= {WIN_W{1'b0}};
      q_ctrl <= {CTRL_W{1'b0}};
    end else if (load) begin
      q_inst <= d_inst;
      q_rega <= d_rega;
      q_regb <= d_regb;
      q_win  <= d_win;
      q_ctrl <= d_ctrl;
    end else begin
      q_inst <= q_inst;
      q_rega <= q_rega;
      q_regb <= q_regb;
      q_win  <= q_win;
      q_ctrl <= q_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register with valid/ready handshake, flush and
// bubble insertion. Outputs come from the main slot flops; an empty stage
// presents NOP_INST with zero operands/window/control.
// SKID=1: two entries (main + skid), in_ready registered.
// SKID=0: single entry, in_ready = !out_valid | out_ready.
// Ports:
//   clk, rst_n, flush                 clock, sync active-low reset, discard all
//   in_valid/in_ready, in_*           upstream handshake and payload
//   out_valid/out_ready, out_*        downstream handshake and payload
//   occupancy                         entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                INST_W   = pipe_pkg::INST_W_DEF,
  parameter int                DATA_W   = pipe_pkg::DATA_W_DEF,
  parameter int                WIN_W    = pipe_pkg::WIN_W_DEF,
  parameter int                CTRL_W   = pipe_pkg::CTRL_W,
  parameter logic [INST_W-1:0] NOP_INST = pipe_pkg::NOP_INST,
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_rega,
  input  logic [DATA_W-1:0] in_regb,
  input  logic [WIN_W-1:0]  in_win,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_rega,
  output logic [DATA_W-1:0] out_regb,
  output logic [WIN_W-1:0]  out_win,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  import pipe_pkg::*;

  state_e      state_r;
  state_e      next_state_s;
  logic        out_valid_r;
  logic [1:0]  occupancy_r;
  logic        accept_s;
  logic        consume_s;
  logic        main_load_s;
  logic        main_clear_s;
  logic        main_from_skid_s;
  logic        skid_load_s;
  logic        skid_clear_s;

  logic [INST_W-1:0] skid_inst_s;
  logic [DATA_W-1:0] skid_rega_s;
  logic [DATA_W-1:0] skid_regb_s;
  logic [WIN_W-1:0]  skid_win_s;
  logic [CTRL_W-1:0] skid_ctrl_s;

  logic [INST_W-1:0] main_d_inst_s;
  logic [DATA_W-1:0] main_d_rega_s;
  logic [DATA_W-1:0] main_d_regb_s;
  logic [WIN_W-1:0]  main_d_win_s;
  logic [CTRL_W-1:0] main_d_ctrl_s;

  assign accept_s  = in_valid & in_ready;
  assign consume_s = out_valid_r & out_ready;
  assign out_valid = out_valid_r;
  assign occupancy = occupancy_r;

  // Next-state and slot-control decode; flush overrides the handshake.
  always_comb begin
    next_state_s     = state_r;
    main_load_s      = 1'b0;
    main_clear_s     = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (flush) begin
      // Same-cycle in_valid is dropped; a same-cycle consume still completes.
      next_state_s = ST_EMPTY;
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            next_state_s = ST_FULL;
            main_load_s  = 1'b1;
          end else begin
            next_state_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && consume_s) begin
            next_state_s = ST_FULL;
            main_load_s  = 1'b1;
          end else if (accept_s && SKID) begin
            // Main is stalled: park the new entry behind it.
            next_state_s = ST_SKID;
            skid_load_s  = 1'b1;
          end else if (consume_s) begin
            next_state_s = ST_EMPTY;
            main_clear_s = 1'b1;
          end else begin
            next_state_s = ST_FULL;
          end
        end
        ST_SKID: begin
          if (consume_s) begin
            next_state_s     = ST_FULL;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
          end else begin
            next_state_s = ST_SKID;
          end
        end
        default: begin
          next_state_s = ST_EMPTY;
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State register with valid and occupancy registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s != ST_EMPTY);
      occupancy_r <= state_occupancy(next_state_s);
    end
  end

  // Main slot source: the skid entry drains first to keep FIFO order.
  always_comb begin
    if (main_from_skid_s) begin
      main_d_inst_s = skid_inst_s;
      main_d_rega_s = skid_rega_s;
      main_d_regb_s = skid_regb_s;
      main_d_win_s  = skid_win_s;
      main_d_ctrl_s = skid_ctrl_s;
    end else begin
      main_d_inst_s = in_inst;
      main_d_rega_s = in_rega;
      main_d_regb_s = in_regb;
      main_d_win_s  = in_win;
      main_d_ctrl_s = in_ctrl;
    end
  end

  pipe_slot #(
    .INST_W(INST_W), .DATA_W(DATA_W), .WIN_W(WIN_W), .CTRL_W(CTRL_W), .NOP_INST(NOP_INST)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load_s), .clear(main_clear_s),
    .d_inst(main_d_inst_s), .d_rega(main_d_rega_s), .d_regb(main_d_regb_s),
    .d_win(main_d_win_s), .d_ctrl(main_d_ctrl_s),
    .q_inst(out_inst), .q_rega(out_rega), .q_regb(out_regb),
    .q_win(out_win), .q_ctrl(out_ctrl)
  );

  if (SKID) begin : g_skid
    logic in_ready_r;

    // Registered ready: only a full skid slot refuses input.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        in_ready_r <= 1'b1;
      end else begin
        in_ready_r <= (next_state_s != ST_SKID);
      end
    end

    assign in_ready = in_ready_r;

    pipe_slot #(
      .INST_W(INST_W), .DATA_W(DATA_W), .WIN_W(WIN_W), .CTRL_W(CTRL_W), .NOP_INST(NOP_INST)
    ) u_skid (
      .clk(clk), .rst_n(rst_n), .load(skid_load_s), .clear(skid_clear_s),
      .d_inst(in_inst), .d_rega(in_rega), .d_regb(in_regb),
      .d_win(in_win), .d_ctrl(in_ctrl),
      .q_inst(skid_inst_s), .q_rega(skid_rega_s), .q_regb(skid_regb_s),
      .q_win(skid_win_s), .q_ctrl(skid_ctrl_s)
    );
  end else begin : g_noskid
    logic skid_ctl_unused_s;

    assign skid_ctl_unused_s = skid_load_s | skid_clear_s;
    assign in_ready    = ~out_valid_r | out_ready;
    assign skid_inst_s = NOP_INST;
    assign skid_rega_s = {DATA_W{1'b0}};
    assign skid_regb_s = {DATA_W{1'b0}};
    assign skid_win_s  = {WIN_W{1'b0}};
    assign skid_ctrl_s = {CTRL_W{1'b0}};
  end

endmodule
